// File: rtl/pipe_in_arb.sv
// Purpose: round-robin arbiter and issue stage feeding the entry of a valid/allowin pipeline from N requesters.
// Latency: 1 cycle from a requester handshake to out_valid/out_data/out_id.
// Backpressure: req_allowin drops while the held slot is full and pipe_allowin is low; the slot refills in the cycle it drains.
// Build option: define PIPE_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins, ptr held at 0).
module pipe_in_arb #(
    parameter int WIDTH = 100,
    parameter int N     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req_valid,
    input  logic [N*WIDTH-1:0]   req_data,
    output logic [N-1:0]         req_allowin,
    input  logic                 flush,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [$clog2(N)-1:0] out_id,
    input  logic                 pipe_allowin
);

    localparam int IDW = $clog2(N);

    logic [IDW-1:0]   ptr;
    logic             allowin_int;
    logic             accept_en;
    logic             grant_vld;
    logic [IDW-1:0]   grant_idx;
    logic [IDW-1:0]   scan_idx;
    logic [IDW-1:0]   next_ptr;
    logic             handshake;
    logic [WIDTH-1:0] lane [N];
    logic [WIDTH-1:0] grant_data;

    // The slot can take a new payload when it is empty or is being drained this cycle.
    assign allowin_int = !out_valid || pipe_allowin;
    assign accept_en   = allowin_int && !flush && !rst;
    assign handshake   = accept_en && grant_vld;

    // Split the packed payload bus into per-requester lanes.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            lane[i] = req_data[i*WIDTH +: WIDTH];
        end
    end

    // Pick the first valid requester starting at the scan base and wrapping around.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        for (int k = 0; k < N; k++) begin
`ifdef PIPE_ARB_FIXED_PRIO_EN
            scan_idx = IDW'(k);
`else
            scan_idx = IDW'((int'(ptr) + k) % N);
`endif
            if (!grant_vld && req_valid[scan_idx]) begin
                grant_vld = 1'b1;
                grant_idx = scan_idx;
            end
        end
    end

    // Payload of the winner and the pointer position just past it.
    always_comb begin
        grant_data = lane[grant_idx];
        next_ptr   = (grant_idx == IDW'(N - 1)) ? '0 : grant_idx + IDW'(1);
    end

    // One-hot acceptance to the winner, suppressed by stall, flush or reset.
    always_comb begin
        req_allowin = '0;
        if (handshake) begin
            req_allowin[grant_idx] = 1'b1;
        end
    end

    // Output slot and pointer: reset > flush > handshake > drain-to-empty > hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
            ptr       <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (handshake) begin
            out_valid <= 1'b1;
            out_data  <= grant_data;
            out_id    <= grant_idx;
`ifdef PIPE_ARB_FIXED_PRIO_EN
            ptr       <= '0;
`else
            ptr       <= next_ptr;
`endif
        end else if (allowin_int) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/pipe_in_arb.md
# pipe_in_arb

Round-robin arbiter and issue stage that shares the entry of a valid/allowin pipeline between N requesters. Each cycle it grants at most one requester, registers that requester's payload and index, and presents them downstream as a standard valid/allowin producer. It sits directly in front of the first pipeline stage and uses the same handshake convention as the stages behind it. It also handles a pipeline flush for the slot it owns.

## Interface
Parameters:
- WIDTH, 100, payload width per requester.
- N, 4, number of requesters; N >= 2.
- IDW, $clog2(N), width of the requester index. This is a localparam, not overridable.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  N  per-requester valid.
- req_data  in  N*WIDTH  packed payloads; requester i occupies bits [i*WIDTH +: WIDTH].
- req_allowin  out  N  one-hot or zero; high = requester i's payload is accepted this cycle.
- flush  in  1  discard the held output slot and block grants this cycle.
- out_valid  out  1  registered; held payload is valid.
- out_data  out  WIDTH  registered payload.
- out_id  out  IDW  registered index of the requester that supplied out_data.
- pipe_allowin  in  1  downstream stage can accept out_data this cycle.

## Operation
- Internal signal: allowin_int = !out_valid || pipe_allowin.
- Round-robin pointer ptr (IDW bits):
  - grant = the first i with req_valid[i], scanning ptr, ptr+1, …, N-1, 0, …, ptr-1 (modulo N).
  - If no req_valid bit is set, there is no grant.
- req_allowin[i] = allowin_int && !flush && !rst && grant==i. The path is combinational from req_valid, pipe_allowin, flush and rst.
- Handshake for requester i: req_valid[i] && req_allowin[i].
  - On a handshake: out_valid<=1, out_data<=req_data[i], out_id<=i, ptr<=(i+1) mod N.
- allowin_int && !flush && no request: out_valid<=0; ptr, out_data and out_id are held.
- !allowin_int (output full, downstream stalled): all outputs and ptr are held; req_allowin=0.
- flush: out_valid<=0; no grant; ptr is held; out_data and out_id are don't-care-held.
- Priority: rst > flush > handshake > stall/hold.
- Requester obligation: keep req_valid and req_data stable until accepted. The arbiter does not latch an unaccepted grant; the grant may move to another requester when ptr changes.
- Fairness: a continuously valid requester is accepted within N handshakes.

## Timing
- Reset values: out_valid=0, out_data=0, out_id=0, ptr=0; req_allowin=0 while rst is high.
- Latency: handshake in cycle t → out_valid/out_data/out_id valid from cycle t+1.
- Throughput: one transfer per cycle when pipe_allowin=1 continuously.
  - The output slot is refilled in the same cycle it drains; there are no bubbles.
- Downstream takes out_data in a cycle where out_valid && pipe_allowin.
- Stall: out_valid=1 and pipe_allowin=0 → the registered outputs are frozen for as long as the stall lasts.
- Pointer wrap: a grant to N-1 sets ptr=0.
- Reset or flush asserted mid-stall: out_valid clears on the next edge, regardless of pipe_allowin.
- flush and pipe_allowin both high: the slot is dropped and nothing new enters. The downstream consumer ignores a flushed slot.

## Configuration
- PIPE_ARB_FIXED_PRIO_EN:
  - Defined: fixed priority. The lowest-indexed valid requester wins, ptr is held at 0 permanently, and the fairness guarantee does not apply.
  - Undefined (default): round-robin as described in Operation.
  - Handshake, flush, latency and reset behaviour are identical in both modes.

## Test plan
- Reset, then all req_valid=4'b1111 with req_data[i]=i+0x10 and pipe_allowin=1 → out_id sequence 0,1,2,3,0 on consecutive cycles, out_data 0x10,0x11,0x12,0x13,0x10, with no bubbles.
- req_valid=4'b0100 only → req_allowin=4'b0100. Next cycle: out_valid=1, out_id=2, and ptr=3 is observed via the next grant order.
- Stall: slot full with out_id=1, pipe_allowin=0 for 5 cycles → req_allowin=0 and outputs frozen. On release: out_id=1 is consumed and a new grant is issued in the same cycle.
- flush pulse while out_valid=1 and req_valid=4'b1111 → next cycle out_valid=0, no handshake in the flush cycle, and the next grant follows the unchanged ptr.
- rst asserted mid-stream with out_valid=1 → next edge: out_valid=0, out_id=0, out_data=0; the first post-reset grant goes to requester 0.
- With PIPE_ARB_FIXED_PRIO_EN and req_valid=4'b1010 held → out_id=1 on every cycle and requester 3 is never accepted.
